// File: rtl/isqrt_pkg.sv
// Shared types and helpers for the sequential integer square root.
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int out_w(input int in_w);
        return in_w / 2;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring shift/subtract iteration: brings in two radicand bits, yields one root bit.
module isqrt_step #(
    parameter int OUT_W = 16
) (
    input  logic [OUT_W+1:0] r,
    input  logic [OUT_W-1:0] q,
    input  logic [1:0]       bits,
    output logic [OUT_W+1:0] r_next,
    output logic [OUT_W-1:0] q_next
);

    logic [OUT_W+3:0] r_sh_s;
    logic [OUT_W+3:0] trial_s;
    logic [OUT_W+3:0] diff_s;
    logic             ge_s;

    // Trial subtract of (q<<2)|1; widened so the compare never wraps
    always_comb begin
        r_sh_s  = {r, bits};
        trial_s = {2'b00, q, 2'b01};
        diff_s  = r_sh_s - trial_s;
        ge_s    = (r_sh_s >= trial_s);
        if (ge_s) begin
            r_next = diff_s[OUT_W+1:0];
            q_next = {q[OUT_W-2:0], 1'b1};
        end else begin
            r_next = r_sh_s[OUT_W+1:0];
            q_next = {q[OUT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/isqrt_seq.sv
// Flow-controlled sequential integer square root, one root bit per clock.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int ROUND = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IN_W/2-1:0]      out_root,
    output logic [IN_W/2:0]        out_rem,
    output logic                   out_exact
);

    localparam int OUT_W  = out_w(IN_W);
    localparam int CNT_W  = $clog2(OUT_W);
    localparam bit RND_EN = (ROUND != 0);

    if ((IN_W % 2) != 0 || IN_W < 4) begin : g_bad_width
        $fatal(1, "isqrt_seq: IN_W must be even and at least 4");
    end

    state_t            state_r;
    state_t            next_state_s;
    logic [IN_W-1:0]   rad_r;
    logic [OUT_W-1:0]  q_r;
    logic [OUT_W+1:0]  r_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [OUT_W-1:0]  q_next_s;
    logic [OUT_W+1:0]  r_next_s;
    logic [OUT_W-1:0]  root_rnd_s;

    isqrt_step #(.OUT_W(OUT_W)) u_step (
        .r      (r_r),
        .q      (q_r),
        .bits   (rad_r[IN_W-1 -: 2]),
        .r_next (r_next_s),
        .q_next (q_next_s)
    );

    assign in_ready  = (state_r == IDLE) & ~rst;
    assign out_valid = (state_r == DONE);

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) next_state_s = CALC;
                else          next_state_s = IDLE;
            end
            CALC: begin
                if (cnt_r == {CNT_W{1'b0}}) next_state_s = RND_EN ? RND : DONE;
                else                        next_state_s = CALC;
            end
            RND:  next_state_s = DONE;
            DONE: begin
                if (out_ready) next_state_s = IDLE;
                else           next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Round up when the floor remainder exceeds q, i.e. n >= q^2 + q + 1
    always_comb begin
        root_rnd_s = q_r;
        if (r_r > {2'b00, q_r}) begin
            if (&q_r) root_rnd_s = q_r;
            else      root_rnd_s = q_r + OUT_W'(1);
        end else begin
            root_rnd_s = q_r;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= next_state_s;
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_r     <= {IN_W{1'b0}};
            q_r       <= {OUT_W{1'b0}};
            r_r       <= {(OUT_W+2){1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            out_root  <= {OUT_W{1'b0}};
            out_rem   <= {(OUT_W+1){1'b0}};
            out_exact <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        rad_r <= in_data;
                        q_r   <= {OUT_W{1'b0}};
                        r_r   <= {(OUT_W+2){1'b0}};
                        cnt_r <= CNT_W'(OUT_W - 1);
                    end
                end
                CALC: begin
                    rad_r <= {rad_r[IN_W-3:0], 2'b00};
                    q_r   <= q_next_s;
                    r_r   <= r_next_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == {CNT_W{1'b0}} && !RND_EN) begin
                        out_root  <= q_next_s;
                        out_rem   <= r_next_s[OUT_W:0];
                        out_exact <= (r_next_s == {(OUT_W+2){1'b0}});
                    end
                end
                RND: begin
                    out_root  <= root_rnd_s;
                    out_rem   <= r_r[OUT_W:0];
                    out_exact <= (r_r == {(OUT_W+2){1'b0}});
                end
                DONE: begin
                    out_root <= out_root;
                end
                default: begin
                    out_root <= out_root;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench: directed cases plus randomised radicands on four parameterisations.
module tb_isqrt_seq;

    localparam int ND = 4;
    localparam int WS [ND] = '{32, 32, 16, 4};
    localparam int RS [ND] = '{0, 1, 0, 1};

    logic        clk = 1'b0;
    logic        rst;
    logic        iv    [ND];
    logic [31:0] id    [ND];
    logic        ordy  [ND];
    logic        ir    [ND];
    logic        ov    [ND];
    logic [31:0] oroot [ND];
    logic [31:0] orem  [ND];
    logic        oex   [ND];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int W = WS[g];
        logic [W/2-1:0] root_w;
        logic [W/2:0]   rem_w;
        isqrt_seq #(.IN_W(W), .ROUND(RS[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g][W-1:0]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_root  (root_w),
            .out_rem   (rem_w),
            .out_exact (oex[g])
        );
        assign oroot[g] = 32'(root_w);
        assign orem[g]  = 32'(rem_w);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint floor_sqrt(input longint x);
        longint lo = 0;
        longint hi = 65535;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= x) lo = mid;
            else                hi = mid - 1;
        end
        return lo;
    endfunction

    // Drive one radicand into DUT d, check latency/result/handshake, return observed result
    task automatic run_op(input int d, input logic [31:0] x, input int stall,
                          output logic [31:0] root, output logic [31:0] rem, output logic ex);
        int     ow   = WS[d] / 2;
        longint maxv = (longint'(1) << ow) - 1;
        longint s    = floor_sqrt(longint'(x));
        longint er   = longint'(x) - s * s;
        longint eroot = s;
        int     lat  = 0;
        bit     stable = 1'b1;
        if (RS[d] != 0 && s + 1 <= maxv && (s + 1) * (s + 1) - longint'(x) < er)
            eroot = s + 1;
        @(negedge clk);
        iv[d] = 1'b1;
        id[d] = x;
        chk("in_ready_idle", 64'(ir[d]), 64'd1);
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        id[d] = $urandom;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov[d] && lat < 60);
        chk("latency", 64'(lat), 64'(ow + 1 + RS[d]));
        root = oroot[d];
        rem  = orem[d];
        ex   = oex[d];
        chk("root", 64'(root), 64'(eroot));
        chk("rem", 64'(rem), 64'(er));
        chk("exact", 64'(ex), 64'(er == 0));
        chk("rem_le_2root", 64'(longint'(rem) <= 2 * s), 64'd1);
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (!ov[d] || ir[d] || oroot[d] !== root || orem[d] !== rem || oex[d] !== ex)
                    stable = 1'b0;
            end
            chk("stall_stable", 64'(stable), 64'd1);
        end
        ordy[d] = 1'b1;
        @(posedge clk);
        #1;
        ordy[d] = 1'b0;
        chk("valid_drop_after_accept", 64'(ov[d]), 64'd0);
        chk("ready_after_accept", 64'(ir[d]), 64'd1);
    endtask

    initial begin
        logic [31:0] r_root;
        logic [31:0] r_rem;
        logic        r_ex;
        logic [31:0] x;
        logic [31:0] mask;
        int          seen;

        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            iv[d] = 1'b0; id[d] = 32'd0; ordy[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_ready", 64'(ir[0]), 64'd0);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_root", 64'(oroot[1]), 64'd0);
        chk("rst_rem_exact", 64'({orem[1], oex[1]}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(ir[0]), 64'd1);

        // floor, IN_W=32
        run_op(0, 32'd0, 0, r_root, r_rem, r_ex);
        chk("d_0", 64'({r_root, r_rem[15:0], 7'd0, r_ex}), {32'd0, 16'd0, 8'd1});
        run_op(0, 32'd1, 0, r_root, r_rem, r_ex);
        chk("d_1", 64'({r_root, r_rem[15:0], 7'd0, r_ex}), {32'd1, 16'd0, 8'd1});
        run_op(0, 32'd99, 5, r_root, r_rem, r_ex);
        chk("d_99", 64'({r_root, r_rem[15:0], 7'd0, r_ex}), {32'd9, 16'd18, 8'd0});
        run_op(0, 32'd90, 0, r_root, r_rem, r_ex);
        chk("d_90", 64'({r_root, r_rem[15:0], 7'd0, r_ex}), {32'd9, 16'd9, 8'd0});

        // round-to-nearest, IN_W=32
        run_op(1, 32'd99, 0, r_root, r_rem, r_ex);
        chk("r_99", 64'({r_root, r_rem}), {32'd10, 32'd18});
        run_op(1, 32'd90, 0, r_root, r_rem, r_ex);
        chk("r_90", 64'({r_root, r_rem}), {32'd9, 32'd9});
        run_op(1, 32'hFFFF_FFFF, 3, r_root, r_rem, r_ex);
        chk("r_max_sat", 64'({r_root, r_rem}), {32'd65535, 32'd131070});

        // abort in the middle of CALC
        @(negedge clk);
        iv[0] = 1'b1;
        id[0] = 32'h1234_5678;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_root", 64'(oroot[0]), 64'd0);
        chk("abort_rem_exact", 64'({orem[0], oex[0]}), 64'd0);
        chk("abort_valid_ready", 64'({ov[0], ir[0]}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (ov[0]) seen++;
        end
        chk("no_out_after_abort", 64'(seen), 64'd0);
        run_op(0, 32'd144, 0, r_root, r_rem, r_ex);
        chk("d_144", 64'({r_root, r_rem[15:0], 7'd0, r_ex}), {32'd12, 16'd0, 8'd1});

        // randomised radicands with random stalls on every parameterisation
        for (int d = 0; d < ND; d++) begin
            mask = (WS[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WS[d]) - 32'd1);
            run_op(d, mask, 1, r_root, r_rem, r_ex);
            for (int n = 0; n < 400; n++) begin
                x = $urandom & mask;
                if (n % 4 == 1) x = x >> $urandom_range(0, WS[d] - 1);
                run_op(d, x, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                       r_root, r_rem, r_ex);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
